match_window_counter: RTL

Downstream consumer of the 1101 sequence detector's serial `out` bit. Counts detector match events (rising edges) over fixed windows of WIN_LEN clock cycles. Reports each window's total with a one-cycle valid strobe, plus a threshold alarm and a saturation flag. Sits between the detector and the status/interrupt logic.

---
 rtl/match_window_counter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/match_window_counter.sv
// Windowed edge counter for the 1101 detector's match bit: counts rising edges per WIN_LEN-cycle window.
// Optional cumulative 16-bit `total` output is enabled by defining MATCH_TOTAL_EN.
module match_window_counter #(
  parameter int CNT_W   = 4,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm,
  output logic             win_sat
`ifdef MATCH_TOTAL_EN
  ,
  output logic [15:0]      total
`endif
);

  localparam int WC_W = $clog2(WIN_LEN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A threshold above the counter range can never be reached; clamp it so the compare stays in-width.
  localparam int THR_CLAMP = (THRESH > (2 ** CNT_W)) ? (2 ** CNT_W) : ((THRESH < 0) ? 0 : THRESH);
  localparam logic [CNT_W:0] THR_C = (CNT_W + 1)'(THR_CLAMP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wcyc_q, wcyc_d;
  logic             in_q, in_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic             alarm_q, alarm_d;
  logic             win_sat_q, win_sat_d;
  logic             win_valid_q, win_valid_d;
`ifdef MATCH_TOTAL_EN
  logic [15:0]      total_q, total_d;
`endif

  logic             edge_w;
  logic [CNT_W-1:0] fin;
  logic             sat_hit;

  always_comb begin
    in_d        = in;
    state_d     = state_q;
    wcyc_d      = wcyc_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    win_count_d = win_count_q;
    alarm_d     = alarm_q;
    win_sat_d   = win_sat_q;
    win_valid_d = 1'b0;
`ifdef MATCH_TOTAL_EN
    total_d     = total_q;
`endif
    edge_w  = in & ~in_q;
    fin     = sat_inc(count_q, edge_w);
    sat_hit = edge_w & (count_q == CNT_MAX);

    if (clr) begin
      state_d     = IDLE;
      wcyc_d      = '0;
      count_d     = '0;
      sticky_d    = 1'b0;
      win_count_d = '0;
      alarm_d     = 1'b0;
      win_sat_d   = 1'b0;
`ifdef MATCH_TOTAL_EN
      total_d     = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          wcyc_d   = '0;
          count_d  = '0;
          sticky_d = 1'b0;
          if (en) state_d = RUN;
        end
        RUN: begin
`ifdef MATCH_TOTAL_EN
          total_d = sat_inc16(total_q, edge_w);
`endif
          // The edge seen on the boundary cycle still belongs to the closing window.
          if (wcyc_q == WC_LAST) begin
            win_count_d = fin;
            alarm_d     = ({1'b0, fin} >= THR_C);
            win_sat_d   = sticky_q | sat_hit;
            win_valid_d = 1'b1;
            wcyc_d      = '0;
            count_d     = '0;
            sticky_d    = 1'b0;
            state_d     = en ? RUN : IDLE;
          end else begin
            wcyc_d   = wcyc_q + 1'b1;
            count_d  = fin;
            sticky_d = sticky_q | sat_hit;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcyc_q      <= '0;
      in_q        <= 1'b0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      win_count_q <= '0;
      alarm_q     <= 1'b0;
      win_sat_q   <= 1'b0;
      win_valid_q <= 1'b0;
`ifdef MATCH_TOTAL_EN
      total_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wcyc_q      <= wcyc_d;
      in_q        <= in_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      win_count_q <= win_count_d;
      alarm_q     <= alarm_d;
      win_sat_q   <= win_sat_d;
      win_valid_q <= win_valid_d;
`ifdef MATCH_TOTAL_EN
      total_q     <= total_d;
`endif
    end
  end

  assign count     = count_q;
  assign win_count = win_count_q;
  assign win_valid = win_valid_q;
  assign alarm     = alarm_q;
  assign win_sat   = win_sat_q;
`ifdef MATCH_TOTAL_EN
  assign total     = total_q;
`endif

endmodule
